apb_rr_master: RTL and testbench
================================

Name: apb_rr_master

Overview:
- Round-robin APB master that shares one APB slave (e.g. the timer peripheral, 5-bit register space) between `req_n` local requesters.
- Each requester presents a simple req/ack register-access interface. The block arbitrates, runs the APB SETUP/ACCESS sequence and returns read data and error status.
- A watchdog aborts transfers when the slave holds `pready` low too long.

Parameters:
- `req_n`, 2, number of requesters (2..8).
- `tmo_lim`, 255, max ACCESS cycles with `pready`=0 before abort; 0 disables timeout.
- `tmo_w`, 8, timeout counter width; requires `tmo_lim` < 2^`tmo_w`.

Ports:
- `pclk`  in  1  clock
- `presetn`  in  1  asynchronous active-low reset
- `req`  in  req_n  access request per requester
- `req_addr`  in  req_n*5  register address, requester i at [i*5 +: 5]
- `req_we`  in  req_n  1 = write, 0 = read
- `req_wd`  in  req_n*32  write data, requester i at [i*32 +: 32]
- `ack`  out  req_n  one-hot completion strobe
- `rd`  out  32  read data, valid while any `ack` bit is high
- `err`  out  1  error status, valid while any `ack` bit is high
- `busy`  out  1  FSM not in IDLE
- `paddr`  out  5  APB address
- `pwdata`  out  32  APB write data
- `pwrite`  out  1  APB direction
- `psel`  out  1  APB select
- `penable`  out  1  APB enable
- `prdata`  in  32  APB read data
- `pready`  in  1  APB ready
- `pslverr`  in  1  APB slave error

Behaviour:
- Reset (async, `presetn`=0):
  - FSM to IDLE.
  - `psel`, `penable`, `pwrite`, `paddr`, `pwdata` = 0.
  - Grant index = 0; last-grant pointer = req_n-1, so requester 0 has top priority first.
  - Timeout counter = 0.
  - `ack` = 0, `busy` = 0.
  - Reset mid-transfer drops `psel`/`penable` immediately. No `ack` is issued for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: if any `req` bit is high, pick the first set bit searching upward (with wrap) from last-grant+1. Register the grant index, `paddr`/`pwdata`/`pwrite` from that requester, and the last-grant pointer. Go to SETUP. Otherwise stay in IDLE.
  - SETUP: `psel`=1, `penable`=0. Unconditionally go to ACCESS.
  - ACCESS: `psel`=1, `penable`=1, outputs stable.
    - `pready`=1: transfer completes this cycle; go to IDLE.
    - `pready`=0 and `tmo_lim`≠0 and counter == `tmo_lim`-1: abort; go to IDLE.
    - Otherwise the counter increments.
  - IDLE always clears `psel`/`penable` and the counter.
- Completion (combinational, ACCESS cycle only):
  - On `pready`=1: `ack[gnt]`=1, `rd`=`prdata` (0 for writes), `err`=`pslverr`.
  - On timeout abort: `ack[gnt]`=1, `rd`=0, `err`=1.
  - Outside completion, `ack`=0, `rd`=0, `err`=0.
- Requester rules:
  - Hold `req` and all request fields stable from assertion until the `ack` cycle.
  - Drop `req` at the edge ending the `ack` cycle, or keep it high to issue a new request.
  - Request fields are sampled only in the IDLE grant cycle.
- Latency: `req` high in IDLE cycle 0 → SETUP cycle 1 → ACCESS cycle 2 → `ack` in cycle 2+W, where W = slave wait states.
  - Minimum transfer spacing is 3 cycles, because IDLE is always revisited.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,req_n-1,0. No requester waits more than req_n-1 transfers.
- A request arriving while `busy`=1 is held pending. The grant is evaluated only in IDLE.
- `busy` = (state ≠ IDLE).

Test Plan:
- Single write: `req[0]`=1, `addr`=5'h04, `wd`=32'hDEADBEEF, `pready` tied 1 → `psel` rises cycle 1, `penable` cycle 2, `paddr`=04, `pwdata`=DEADBEEF, `pwrite`=1. `ack`=2'b01 in cycle 2; `err`=0.
- Read with 3 wait states: `req[1]` read, `addr`=5'h08, slave returns `prdata`=32'h0000_00A5 on 4th ACCESS cycle → `ack`=2'b10 exactly then, `rd`=A5, `psel`/`penable` low next cycle.
- Contention: `req`=2'b11 held continuously after reset → grant order 0,1,0,1. Each `ack` is 3 cycles apart with `pready`=1.
- Slave error: `pslverr`=1 with `pready`=1 on a write → `ack` pulses with `err`=1. Next grant proceeds normally.
- Timeout: `tmo_lim`=4, `pready` stuck 0 → ACCESS lasts 4 cycles. `ack` with `err`=1, `rd`=0 on the 4th; `busy`=0 the next cycle.
- Reset mid-ACCESS: assert `presetn`=0 while `penable`=1 → `psel`/`penable`/`ack`=0 immediately. After release, `req`=2'b11 is granted to requester 0 first.

Source files
------------

// File: rtl/apb_rr_master_if.sv
// Requester-side and APB-side signals of the round-robin APB master.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface apb_rr_master_if #(
    parameter int req_n = 2
);
    logic [req_n-1:0]    req;
    logic [req_n*5-1:0]  req_addr;
    logic [req_n-1:0]    req_we;
    logic [req_n*32-1:0] req_wd;
    logic [req_n-1:0]    ack;
    logic [31:0]         rd;
    logic                err;
    logic                busy;
    logic [4:0]          paddr;
    logic [31:0]         pwdata;
    logic                pwrite;
    logic                psel;
    logic                penable;
    logic [31:0]         prdata;
    logic                pready;
    logic                pslverr;

    modport master (
        input  req, req_addr, req_we, req_wd, prdata, pready, pslverr,
        output ack, rd, err, busy, paddr, pwdata, pwrite, psel, penable
    );

    modport slave (
        output req, req_addr, req_we, req_wd, prdata, pready, pslverr,
        input  ack, rd, err, busy, paddr, pwdata, pwrite, psel, penable
    );
endinterface

// File: rtl/apb_rr_master.sv
// Round-robin APB master: shares one APB slave between req_n requesters,
// runs SETUP/ACCESS, returns read data / error and aborts stalled transfers.
module apb_rr_master #(
    parameter int req_n   = 2,
    parameter int tmo_lim = 255,
    parameter int tmo_w   = 8
) (
    input  logic             pclk,
    input  logic             presetn,
    apb_rr_master_if.master  bus
);
    localparam int GW = (req_n > 1) ? $clog2(req_n) : 1;
    localparam logic [tmo_w-1:0] TMO_LAST = (tmo_lim == 0) ? '0 : tmo_w'(tmo_lim - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t           state_q;
    logic [GW-1:0]    gnt_q;
    logic [GW-1:0]    last_q;
    logic [tmo_w-1:0] cnt_q;
    logic [4:0]       paddr_q;
    logic [31:0]      pwdata_q;
    logic             pwrite_q;
    logic             psel_q;
    logic             penable_q;

    logic [4:0]  addr_a [req_n];
    logic [31:0] wd_a   [req_n];

    for (genvar i = 0; i < req_n; i++) begin : g_lane
        assign addr_a[i] = bus.req_addr[i*5 +: 5];
        assign wd_a[i]   = bus.req_wd[i*32 +: 32];
    end

    // Scan downward so the candidate closest after last_q is the one kept.
    logic          pick_vld_d;
    logic [GW-1:0] pick_d;
    logic [GW-1:0] cand_d;
    always_comb begin
        pick_vld_d = 1'b0;
        pick_d     = '0;
        cand_d     = '0;
        for (int k = req_n; k >= 1; k--) begin
            cand_d = GW'((int'(last_q) + k) % req_n);
            if (bus.req[cand_d]) begin
                pick_vld_d = 1'b1;
                pick_d     = cand_d;
            end
        end
    end

    logic in_acc, done, tmo, fin;
    assign in_acc = (state_q == ACCESS);
    assign done   = in_acc && bus.pready;
    assign tmo    = in_acc && !bus.pready && (tmo_lim != 0) && (cnt_q == TMO_LAST);
    assign fin    = done || tmo;

    always_comb begin
        bus.ack = '0;
        if (fin) bus.ack[gnt_q] = 1'b1;
    end

    assign bus.rd      = (done && !pwrite_q) ? bus.prdata : '0;
    assign bus.err     = done ? bus.pslverr : tmo;
    assign bus.busy    = (state_q != IDLE);
    assign bus.paddr   = paddr_q;
    assign bus.pwdata  = pwdata_q;
    assign bus.pwrite  = pwrite_q;
    assign bus.psel    = psel_q;
    assign bus.penable = penable_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            last_q    <= GW'(req_n - 1);
            cnt_q     <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    cnt_q     <= '0;
                    if (pick_vld_d) begin
                        gnt_q    <= pick_d;
                        last_q   <= pick_d;
                        paddr_q  <= addr_a[pick_d];
                        pwdata_q <= wd_a[pick_d];
                        pwrite_q <= bus.req_we[pick_d];
                        psel_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (fin) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: directed vector table, hand-written corner sequences,
// then random requesters/slave checked against a transaction-level model.
module tb_apb_rr_master;
    localparam int NREQ = 2;
    localparam int TMO  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    apb_rr_master_if #(.req_n(NREQ)) bus();

    apb_rr_master #(.req_n(NREQ), .tmo_lim(TMO), .tmo_w(8)) dut (
        .pclk(clk),
        .presetn(rst_n),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    int          sl_w;
    logic        sl_err;
    logic [31:0] sl_rdata;
    bit          rand_mode;
    int          acc_k;
    logic [31:0] mem [32];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Slave behaviour: ready after sl_w ACCESS cycles, junk on idle inputs.
    task automatic settle();
        if (bus.psel && bus.penable) begin
            bus.pready  = (acc_k == sl_w);
            bus.prdata  = bus.pready ? (rand_mode ? mem[bus.paddr] : sl_rdata) : $urandom;
            bus.pslverr = sl_err;
            acc_k++;
        end else begin
            if (bus.psel && rand_mode) begin
                sl_w   = $urandom_range(0, 5);
                sl_err = ($urandom_range(0, 3) == 0);
            end
            bus.pready  = 1'($urandom_range(0, 1));
            bus.prdata  = $urandom;
            bus.pslverr = 1'($urandom_range(0, 1));
            acc_k = 0;
        end
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [4:0] a, input logic [31:0] wd);
        bus.req[i]              = v;
        bus.req_we[i]           = we;
        bus.req_addr[i*5 +: 5]  = a;
        bus.req_wd[i*32 +: 32]  = wd;
    endtask

    task automatic do_reset(input bit check);
        bus.req = '0;
        rst_n = 1'b0;
        #1;
        if (check) begin
            chk("rst_psel",    bus.psel,    0);
            chk("rst_penable", bus.penable, 0);
            chk("rst_pwrite",  bus.pwrite,  0);
            chk("rst_paddr",   bus.paddr,   0);
            chk("rst_pwdata",  bus.pwdata,  0);
            chk("rst_ack",     bus.ack,     0);
            chk("rst_busy",    bus.busy,    0);
        end
        cyc();
        rst_n = 1'b1;
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    typedef struct {
        int          r;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wd;
        int          w;
        logic        slverr;
        logic [31:0] rdat;
        logic [1:0]  eack;
        logic [31:0] erd;
        logic        eerr;
        int          elat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nack;
        int ack_cyc [4];
        logic [1:0] ack_val [4];
        logic [NREQ-1:0] prev_req;
        bit prev_fin;
        int m_ph, m_g, m_last, m_k;
        bit pend [NREQ];
        bit done_i [NREQ];

        bus.req = '0; bus.req_addr = '0; bus.req_we = '0; bus.req_wd = '0;
        bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;
        rand_mode = 1'b0; sl_w = 0; sl_err = 1'b0; sl_rdata = '0; acc_k = 0;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        rst_n = 1'b1;
        #3;
        do_reset(1'b1);

        //            r we addr   wd            w  err rdat          eack   erd           eerr lat
        vecs[0] = '{0, 1, 5'h04, 32'hDEADBEEF, 0,  0, 32'h11111111, 2'b01, 32'h0,        0,   2};
        vecs[1] = '{1, 0, 5'h08, 32'h0,        3,  0, 32'h000000A5, 2'b10, 32'h000000A5, 0,   5};
        vecs[2] = '{0, 1, 5'h1F, 32'h12345678, 1,  1, 32'h22222222, 2'b01, 32'h0,        1,   3};
        vecs[3] = '{1, 1, 5'h03, 32'hCAFEF00D, 0,  0, 32'h33333333, 2'b10, 32'h0,        0,   2};
        vecs[4] = '{0, 0, 5'h10, 32'h0,        15, 0, 32'h00000055, 2'b01, 32'h0,        1,   5};
        vecs[5] = '{1, 0, 5'h00, 32'h0,        2,  1, 32'h80000001, 2'b10, 32'h80000001, 1,   4};
        vecs[6] = '{0, 0, 5'h0A, 32'h0,        0,  0, 32'hFFFFFFFF, 2'b01, 32'hFFFFFFFF, 0,   2};

        foreach (vecs[v]) begin
            cyc();
            set_req(vecs[v].r, 1'b1, vecs[v].we, vecs[v].addr, vecs[v].wd);
            sl_w = vecs[v].w; sl_err = vecs[v].slverr; sl_rdata = vecs[v].rdat;
            settle();
            chk($sformatf("v%0d_idle_psel", v), bus.psel, 0);
            lat = -1;
            for (int n = 1; n <= 20; n++) begin
                cyc();
                settle();
                if (n == 1) begin
                    chk($sformatf("v%0d_setup_psel", v),    bus.psel,    1);
                    chk($sformatf("v%0d_setup_penable", v), bus.penable, 0);
                    chk($sformatf("v%0d_setup_busy", v),    bus.busy,    1);
                    chk($sformatf("v%0d_paddr", v),         bus.paddr,   vecs[v].addr);
                    chk($sformatf("v%0d_pwdata", v),        bus.pwdata,  vecs[v].wd);
                    chk($sformatf("v%0d_pwrite", v),        bus.pwrite,  vecs[v].we);
                end
                if (bus.ack != '0) begin
                    lat = n;
                    chk($sformatf("v%0d_ack", v),     bus.ack,     vecs[v].eack);
                    chk($sformatf("v%0d_rd", v),      bus.rd,      vecs[v].erd);
                    chk($sformatf("v%0d_err", v),     bus.err,     vecs[v].eerr);
                    chk($sformatf("v%0d_penable", v), bus.penable, 1);
                    break;
                end
            end
            chk($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].elat));
            cyc();
            bus.req[vecs[v].r] = 1'b0;
            settle();
            chk($sformatf("v%0d_after_psel", v),    bus.psel,    0);
            chk($sformatf("v%0d_after_penable", v), bus.penable, 0);
            chk($sformatf("v%0d_after_busy", v),    bus.busy,    0);
            chk($sformatf("v%0d_after_ack", v),     bus.ack,     0);
        end

        // Contention: both requesters held high from reset.
        do_reset(1'b0);
        sl_w = 0; sl_err = 1'b0; sl_rdata = 32'h0;
        cyc();
        set_req(0, 1'b1, 1'b1, 5'h01, 32'h1);
        set_req(1, 1'b1, 1'b1, 5'h02, 32'h2);
        settle();
        nack = 0;
        for (int n = 1; n <= 20 && nack < 4; n++) begin
            cyc();
            settle();
            if (bus.ack != '0) begin
                ack_cyc[nack] = n;
                ack_val[nack] = bus.ack;
                nack++;
            end
        end
        chk("cont_nack", 64'(nack), 4);
        for (int j = 0; j < nack; j++) begin
            chk($sformatf("cont_ack%0d", j), ack_val[j], (j % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("cont_cyc%0d", j), 64'(ack_cyc[j]), 64'(2 + 3 * j));
        end
        cyc();
        bus.req = '0;
        settle();

        // Reset while requester 1 is in ACCESS; requester 0 must win afterwards.
        do_reset(1'b0);
        sl_w = 0; sl_err = 1'b0; sl_rdata = 32'h5A;
        cyc();
        set_req(0, 1'b1, 1'b0, 5'h05, 32'h0);
        set_req(1, 1'b1, 1'b0, 5'h06, 32'h0);
        settle();
        lat = -1;
        for (int n = 1; n <= 10; n++) begin
            cyc(); settle();
            if (bus.ack != '0) begin lat = n; chk("mr_first_ack", bus.ack, 2'b01); break; end
        end
        chk("mr_first_lat", 64'(lat), 2);
        sl_w = 15;
        lat = -1;
        for (int n = 1; n <= 10; n++) begin
            cyc(); settle();
            if (bus.psel && bus.penable) begin lat = n; break; end
        end
        chk("mr_reach_access", 64'(lat), 3);
        chk("mr_access_paddr", bus.paddr, 5'h06);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_psel",    bus.psel,    0);
        chk("mr_penable", bus.penable, 0);
        chk("mr_ack",     bus.ack,     0);
        chk("mr_busy",    bus.busy,    0);
        cyc();
        rst_n = 1'b1;
        sl_w = 0;
        lat = -1;
        for (int n = 1; n <= 10; n++) begin
            cyc(); settle();
            if (bus.psel && !bus.penable && lat < 0) begin
                lat = n;
                chk("mr_regrant_paddr", bus.paddr, 5'h05);
            end
            if (bus.ack != '0) begin chk("mr_regrant_ack", bus.ack, 2'b01); break; end
        end
        chk("mr_regrant_seen", 64'(lat), 1);

        // Random requesters and slave against a transaction-level model.
        do_reset(1'b0);
        rand_mode = 1'b1;
        prev_req = '0; prev_fin = 1'b0;
        m_ph = 0; m_g = 0; m_last = NREQ - 1; m_k = 0;
        for (int i = 0; i < NREQ; i++) begin pend[i] = 0; done_i[i] = 0; end
        for (int c = 0; c < 3000; c++) begin
            bit ok_done, abort, fin;
            logic [NREQ-1:0] e_ack;
            logic [31:0] e_rd;
            logic e_err;
            logic [4:0] a_g;
            cyc();
            for (int i = 0; i < NREQ; i++) begin
                if (done_i[i]) begin pend[i] = 0; done_i[i] = 0; end
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1;
                    set_req(i, 1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
                end
                bus.req[i] = pend[i];
            end
            settle();

            case (m_ph)
                0: if (prev_req != '0) begin
                       m_g = rr_pick(prev_req, m_last);
                       m_last = m_g;
                       m_ph = 1;
                   end
                1: begin m_ph = 2; m_k = 0; end
                default: if (prev_fin) m_ph = 0; else m_k++;
            endcase

            ok_done = (m_ph == 2) && (m_k == sl_w);
            abort   = (m_ph == 2) && !ok_done && (m_k == TMO - 1);
            fin     = ok_done || abort;
            e_ack = '0;
            e_rd  = '0;
            e_err = 1'b0;
            a_g   = bus.req_addr[m_g*5 +: 5];
            if (fin) e_ack[m_g] = 1'b1;
            if (ok_done && !bus.req_we[m_g]) e_rd = mem[a_g];
            if (ok_done) e_err = sl_err;
            else if (abort) e_err = 1'b1;

            chk("rnd_busy",    bus.busy,    (m_ph != 0));
            chk("rnd_psel",    bus.psel,    (m_ph != 0));
            chk("rnd_penable", bus.penable, (m_ph == 2));
            chk("rnd_ack",     bus.ack,     e_ack);
            chk("rnd_rd",      bus.rd,      e_rd);
            chk("rnd_err",     bus.err,     e_err);
            if (m_ph != 0) begin
                chk("rnd_paddr",  bus.paddr,  a_g);
                chk("rnd_pwrite", bus.pwrite, bus.req_we[m_g]);
                chk("rnd_pwdata", bus.pwdata, bus.req_wd[m_g*32 +: 32]);
            end

            if (ok_done && bus.req_we[m_g]) mem[a_g] = bus.req_wd[m_g*32 +: 32];
            if (fin) done_i[m_g] = 1;
            prev_req = bus.req;
            prev_fin = fin;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
